instr_fetch_stage: RTL and testbench

//  Fetch-side initiator for the instruction memory: owns the PC, drives imem_addr/imem_req,

---
 rtl/arm_pkg.sv | 18 +
 rtl/instr_fetch_stage_if_id_reg.sv | 38 +++
 rtl/instr_fetch_stage.sv | 109 ++++++++++
 tb/tb_instr_fetch_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared constants and types for the instruction fetch stage.
package arm_pkg;

  localparam int          ADDR_W    = 32;
  localparam int          DATA_W    = 32;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // S_FETCH  : request issued, expecting data this cycle
  // S_WAIT   : memory inserted wait states, address held
  // S_SQUASH : redirect pending, outstanding fetch will be thrown away
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_SQUASH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load, hold, flush (valid=0, instr=NOP) or bubble (valid=0 only).
module if_id_reg
  import arm_pkg::*;
#(
  parameter int ADDR_W = arm_pkg::ADDR_W,
  parameter int DATA_W = arm_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic              bubble,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] instr_in,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              valid
);

  // Flush beats load beats bubble; with none asserted the register holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      instr <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= DATA_W'(NOP_INSTR);
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end else if (bubble) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the fetch FSM
// that tolerates wait-state memories and squashes fetches hit by a redirect.
module instr_fetch_stage
  import arm_pkg::*;
#(
  parameter int                ADDR_W   = arm_pkg::ADDR_W,
  parameter int                DATA_W   = arm_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(arm_pkg::PC_STEP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              imem_req_o,
  input  logic              imem_ready_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_instr_o,
  output logic              if_valid_o
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redirect_q;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic              ifid_load;
  logic              ifid_flush;
  logic              ifid_bubble;

  // Branch targets are word aligned; the low two bits are dropped.
  assign target = {branch_addr_i[ADDR_W-1:2], 2'b00};
  // Wraps modulo 2^ADDR_W by construction.
  assign pc_inc = pc + PC_STEP;

  // The address is always the registered PC so it stays stable across wait states.
  assign imem_addr_o = pc;
  assign imem_req_o  = ~rst;

  // IF/ID control: a branch always flushes, freeze only ever holds.
  always_comb begin
    ifid_load   = 1'b0;
    ifid_flush  = 1'b0;
    ifid_bubble = 1'b0;
    case (state)
      S_FETCH, S_WAIT: begin
        if (branch_taken_i)  ifid_flush  = 1'b1;
        else if (freeze_i)   ifid_load   = 1'b0;
        else if (imem_ready_i) ifid_load = 1'b1;
        else                 ifid_bubble = 1'b1;
      end
      S_SQUASH: ifid_flush = 1'b1;
      default:  ifid_flush = 1'b1;
    endcase
  end

  // Fetch FSM together with the PC and the pending redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      redirect_q <= '0;
    end else begin
      case (state)
        S_FETCH, S_WAIT: begin
          if (imem_ready_i) begin
            state <= S_FETCH;
            if (branch_taken_i)  pc <= target;
            else if (!freeze_i)  pc <= pc_inc;
          end else if (branch_taken_i) begin
            redirect_q <= target;
            state      <= S_SQUASH;
          end else begin
            state <= S_WAIT;
          end
        end
        S_SQUASH: begin
          if (imem_ready_i) begin
            pc    <= branch_taken_i ? target : redirect_q;
            state <= S_FETCH;
          end else if (branch_taken_i) begin
            redirect_q <= target;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .bubble  (ifid_bubble),
    .pc_in   (pc_inc),
    .instr_in(imem_rdata_i),
    .pc      (if_pc_o),
    .instr   (if_instr_o),
    .valid   (if_valid_o)
  );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios followed by random traffic,
// all checked against a cycle-level transaction model of the fetch rules.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [31:0] m_addr;
  logic [31:0] m_redir;
  logic        m_squash;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;

  instr_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .freeze_i      (freeze),
    .branch_taken_i(branch_taken),
    .branch_addr_i (branch_addr),
    .imem_addr_o   (imem_addr),
    .imem_req_o    (imem_req),
    .imem_ready_i  (imem_ready),
    .imem_rdata_i  (imem_rdata),
    .if_pc_o       (if_pc),
    .if_instr_o    (if_instr),
    .if_valid_o    (if_valid)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0022_0000;
    if (a == 32'h4) return 32'h0064_0000;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_reset();
    m_addr   = 32'h0;
    m_redir  = 32'h0;
    m_squash = 1'b0;
    m_pc     = 32'h0;
    m_instr  = 32'h0;
    m_valid  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"}, imem_addr, m_addr);
    chk({tag, ".req"}, {31'b0, imem_req}, 32'd1);
    chk({tag, ".valid"}, {31'b0, if_valid}, {31'b0, m_valid});
    chk({tag, ".instr"}, if_instr, m_instr);
    if (m_valid) chk({tag, ".pc"}, if_pc, m_pc);
  endtask

  // One clock: drive inputs at the negedge, update the model, compare 1 time unit after posedge.
  task automatic step(input string tag, input bit rdy, input bit br, input logic [31:0] tgt, input bit frz);
    logic [31:0] t;
    logic [31:0] d;
    t = {tgt[31:2], 2'b00};
    d = mem_word(m_addr);
    imem_ready   = rdy;
    branch_taken = br;
    branch_addr  = tgt;
    freeze       = frz;
    imem_rdata   = rdy ? mem_word(imem_addr) : $urandom;
    @(posedge clk);
    #1;
    if (m_squash) begin
      m_valid = 1'b0;
      m_instr = 32'h0;
      if (rdy) begin
        m_addr   = br ? t : m_redir;
        m_squash = 1'b0;
      end else if (br) begin
        m_redir = t;
      end
    end else if (br) begin
      m_valid = 1'b0;
      m_instr = 32'h0;
      if (rdy) m_addr = t;
      else begin
        m_redir  = t;
        m_squash = 1'b1;
      end
    end else if (rdy) begin
      if (!frz) begin
        m_pc    = m_addr + 32'd4;
        m_instr = d;
        m_valid = 1'b1;
        m_addr  = m_addr + 32'd4;
      end
    end else if (!frz) begin
      m_valid = 1'b0;
    end
    branch_taken = 1'b0;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    // reset state
    #2;
    chk("rst.req", {31'b0, imem_req}, 32'd0);
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.valid", {31'b0, if_valid}, 32'd0);
    chk("rst.instr", if_instr, 32'h0);
    chk("rst.pc", if_pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel.req", {31'b0, imem_req}, 32'd1);
    chk("rel.addr", imem_addr, 32'h0);
    @(negedge clk);

    // 1: zero-wait streaming
    step("t1a", 1, 0, 0, 0);
    chk("t1a.instr_const", if_instr, 32'h0022_0000);
    chk("t1a.pc_const", if_pc, 32'h4);
    step("t1b", 1, 0, 0, 0);
    chk("t1b.instr_const", if_instr, 32'h0064_0000);
    chk("t1b.pc_const", if_pc, 32'h8);
    chk("t1b.addr_const", imem_addr, 32'h8);

    // 2: freeze three cycles at pc=8
    for (int i = 0; i < 3; i++) begin
      step("t2", 1, 0, 0, 1);
      chk("t2.addr_const", imem_addr, 32'h8);
      chk("t2.pc_const", if_pc, 32'h8);
    end
    step("t2r", 1, 0, 0, 0);

    // 3: branch to 0x103 at pc=12 with freeze also high
    chk("t3.addr_pre", imem_addr, 32'hC);
    step("t3a", 1, 1, 32'h0000_0103, 1);
    chk("t3a.addr_const", imem_addr, 32'h100);
    chk("t3a.valid_const", {31'b0, if_valid}, 32'd0);
    step("t3b", 1, 0, 0, 0);
    chk("t3b.pc_const", if_pc, 32'h104);

    // 4: wait states at 0x10, branch to 0x40 during first wait clock
    step("t4pre", 1, 1, 32'h10, 0);
    step("t4a", 0, 1, 32'h40, 0);
    chk("t4a.addr_held", imem_addr, 32'h10);
    step("t4b", 0, 0, 0, 0);
    chk("t4b.addr_held", imem_addr, 32'h10);
    step("t4c", 1, 0, 0, 0);
    chk("t4c.addr_const", imem_addr, 32'h40);
    chk("t4c.valid_const", {31'b0, if_valid}, 32'd0);
    step("t4d", 1, 0, 0, 0);

    // 5: wrap at top of address space
    step("t5a", 1, 1, 32'hFFFF_FFFC, 0);
    chk("t5a.addr_const", imem_addr, 32'hFFFF_FFFC);
    step("t5b", 1, 0, 0, 0);
    chk("t5b.addr_const", imem_addr, 32'h0);
    chk("t5b.pc_const", if_pc, 32'h0);

    // 6: asynchronous reset in the middle of a wait
    step("t6w", 1, 1, 32'h80, 0);
    step("t6w2", 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6.req", {31'b0, imem_req}, 32'd0);
    chk("t6.addr", imem_addr, 32'h0);
    chk("t6.valid", {31'b0, if_valid}, 32'd0);
    chk("t6.instr", if_instr, 32'h0);
    chk("t6.pc", if_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step("t6a", 1, 0, 0, 0);
    chk("t6a.instr_const", if_instr, 32'h0022_0000);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit rdy;
      bit br;
      bit frz;
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 9) == 0);
      frz = ($urandom_range(0, 4) == 0);
      step("rnd", rdy, br, $urandom, frz);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
